// File: rtl/intrapred_pkg.sv
// Shared types and constants for the intra-prediction loop: pixel/residual types,
// the writer FSM encoding and the clipping helper used by each reconstruction lane.
package intrapred_pkg;

  typedef logic [7:0]        pixel_t;
  typedef logic signed [8:0] resid_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Neutral pixel value used when no neighbour data exists yet.
  localparam pixel_t PIXEL_MID = 8'd128;

  // The sum spans -256..510, so bit 9 flags underflow and bit 8 flags overflow.
  function automatic pixel_t clip_pixel(input pixel_t pred, input resid_t resid);
    logic signed [9:0] sum;
    sum = $signed({2'b00, pred}) + $signed({resid[8], resid});
    if (sum[9])
      return 8'd0;
    else if (sum[8])
      return 8'hFF;
    else
      return sum[7:0];
  endfunction

endpackage

// File: rtl/recon_clip.sv
// One reconstruction lane: pred + resid, clipped to the 0..255 pixel range.
module recon_clip
  import intrapred_pkg::*;
(
  input  logic [7:0] pred,
  input  logic [8:0] resid,
  output logic [7:0] pix
);

  always_comb begin
    pix = clip_pixel(pred, resid);
  end

endmodule

// File: rtl/recon_writer.sv
// Reconstructs one macroblock and writes it row by row into the reconstructed frame.
// Optional neighbour outputs (last row/column of the finished MB) with RECON_NEIGHBOUR_OUT_EN.
//
// Handshakes: an MB transfers on a cycle with in_valid=1 and in_ready=1; inputs are
// sampled only then. A row transfers on a cycle with mem_we=1 and mem_ready=1; while
// mem_ready=0 the writer holds mem_we, mem_addr and mem_wdata unchanged.
module recon_writer
  import intrapred_pkg::*;
#(
  parameter int WIDTH     = 720,
  parameter int LENGTH    = 1280,
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int ADDR_W    = 20
)
(
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [12:0]                       mbnumber,
  input  logic [8*MB_SIZE_L*MB_SIZE_W-1:0]  pred_mb,
  input  logic [9*MB_SIZE_L*MB_SIZE_W-1:0]  resid_mb,
  output logic                              mem_we,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [8*MB_SIZE_W-1:0]            mem_wdata,
  input  logic                              mem_ready,
  output logic                              done,
  output logic                              err,
`ifdef RECON_NEIGHBOUR_OUT_EN
  output logic [8*MB_SIZE_W-1:0]            nb_bottom,
  output logic [8*MB_SIZE_L-1:0]            nb_right,
`endif
  output logic [1:0]                        dbg_state
);

  localparam int NPIX        = MB_SIZE_L * MB_SIZE_W;
  localparam int ROW_W       = 8 * MB_SIZE_W;
  localparam int RW          = $clog2(MB_SIZE_L);
  localparam int MBS_PER_ROW = LENGTH / MB_SIZE_W;
  localparam int MB_TOTAL    = MBS_PER_ROW * (WIDTH / MB_SIZE_L);

  localparam logic [31:0]       MB_TOTAL_U  = MB_TOTAL;
  localparam logic [ADDR_W-1:0] MBS_A       = ADDR_W'(MBS_PER_ROW);
  localparam logic [ADDR_W-1:0] ROW_STRIDE  = ADDR_W'(LENGTH);
  localparam logic [ADDR_W-1:0] MB_ROW_STEP = ADDR_W'(MB_SIZE_L * LENGTH);
  localparam logic [ADDR_W-1:0] MB_COL_STEP = ADDR_W'(MB_SIZE_W);
  localparam logic [RW-1:0]     LAST_ROW    = RW'(MB_SIZE_L - 1);

  state_t state_q, state_d;

  logic [RW-1:0]                   row_q;
  logic [ADDR_W-1:0]               addr_q;
  logic                            err_q;
  logic [MB_SIZE_L-1:0][ROW_W-1:0] mb_q;
  logic [8*NPIX-1:0]               clip_flat;

  logic [ADDR_W-1:0] mbn_a, mb_row_a, mb_col_a, base;
  logic              in_range, accept, row_last;

  genvar p;
  generate
    for (p = 0; p < NPIX; p++) begin : g_clip
      recon_clip u_clip (
        .pred  (pred_mb[8*p +: 8]),
        .resid (resid_mb[9*p +: 9]),
        .pix   (clip_flat[8*p +: 8])
      );
    end
  endgenerate

  // Raster position of the MB's top-left pixel.
  always_comb begin
    mbn_a    = ADDR_W'(mbnumber);
    mb_row_a = mbn_a / MBS_A;
    mb_col_a = mbn_a % MBS_A;
    base     = mb_row_a * MB_ROW_STEP + mb_col_a * MB_COL_STEP;
    in_range = ({19'd0, mbnumber} < MB_TOTAL_U);
  end

  assign accept   = in_valid && (state_q == IDLE);
  assign row_last = (row_q == LAST_ROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = in_range ? WRITE : DONE;
      WRITE:   if (mem_ready && row_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    mem_we    = (state_q == WRITE);
    mem_addr  = addr_q;
    mem_wdata = (state_q == WRITE) ? mb_q[row_q] : '0;
    done      = (state_q == DONE);
    err       = (state_q == DONE) && err_q;
    dbg_state = state_q;
  end

  // Only the clipped MB is kept; row address advances by one frame line per accepted row.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q  <= '0;
      addr_q <= '0;
      err_q  <= 1'b0;
      mb_q   <= '0;
    end else if (accept) begin
      err_q <= !in_range;
      if (in_range) begin
        mb_q   <= clip_flat;
        addr_q <= base;
        row_q  <= '0;
      end
    end else if (state_q == WRITE && mem_ready) begin
      row_q  <= row_q + 1'b1;
      addr_q <= addr_q + ROW_STRIDE;
    end
  end

`ifdef RECON_NEIGHBOUR_OUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nb_bottom <= {MB_SIZE_W{PIXEL_MID}};
      nb_right  <= {MB_SIZE_L{PIXEL_MID}};
    end else if (state_q == DONE && !err_q) begin
      nb_bottom <= mb_q[MB_SIZE_L-1];
      for (int j = 0; j < MB_SIZE_L; j++)
        nb_right[8*j +: 8] <= mb_q[j][8*(MB_SIZE_W-1) +: 8];
    end
  end
`endif

endmodule

// File: doc/recon_writer.md
Name: recon_writer

Overview:
- Back end of the intra-prediction loop; the write-side counterpart of the macroblock extractor.
- Accepts one macroblock's prediction and residual, reconstructs each pixel as clip(pred + resid) to 0..255, and writes the result into the reconstructed-frame memory one MB row per cycle at the raster position given by mbnumber.
- Later extractor passes take their top/left neighbours from this memory.

Parameters:
- WIDTH, 720, frame height in pixel rows
- LENGTH, 1280, frame line length in pixels (row stride)
- MB_SIZE_L, 16, MB rows (2, 4, 8 or 16)
- MB_SIZE_W, 16, MB columns (2, 4, 8 or 16)
- ADDR_W, 20, memory address width; must satisfy 2^ADDR_W >= LENGTH*WIDTH

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  MB offered
- in_ready  out  1  writer can accept
- mbnumber  in  13  raster MB index
- pred_mb  in  8*MB_SIZE_L*MB_SIZE_W  prediction; pixel p = j*MB_SIZE_W+k occupies bits [8p+7:8p], unsigned
- resid_mb  in  9*MB_SIZE_L*MB_SIZE_W  residual; pixel p occupies bits [9p+8:9p], two's complement
- mem_we  out  1  row write strobe
- mem_addr  out  ADDR_W  pixel address of the row's first pixel
- mem_wdata  out  8*MB_SIZE_W  row data; column k at bits [8k+7:8k]
- mem_ready  in  1  memory accepts the write this cycle
- done  out  1  one-cycle pulse when an MB is finished
- err  out  1  one-cycle pulse, coincident with done, for out-of-range mbnumber

Behaviour:
- Derived constants:
  - MBS_PER_ROW = LENGTH/MB_SIZE_W
  - MB_TOTAL = MBS_PER_ROW * (WIDTH/MB_SIZE_L)
  - mb_row = mbnumber / MBS_PER_ROW; mb_col = mbnumber % MBS_PER_ROW
  - base = mb_row*MB_SIZE_L*LENGTH + mb_col*MB_SIZE_W, computed at ADDR_W width
- Reset values: in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0; state IDLE; row counter 0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid:
    - if mbnumber < MB_TOTAL: latch the clipped MB and base, set r=0, go to WRITE.
    - otherwise: latch nothing, go to DONE with err flagged.
  - WRITE: in_ready=0; mem_we=1; mem_addr = base + r*LENGTH; mem_wdata = recon row r.
    - If mem_ready: r increments; after r = MB_SIZE_L-1 is accepted, go to DONE.
    - If !mem_ready: hold addr/data/we stable.
  - DONE: done=1 (err=1 if flagged); in_ready=0; next cycle IDLE.
- Latency with no stalls:
  - accept in cycle N
  - first write in cycle N+1
  - last write in cycle N+MB_SIZE_L
  - done in cycle N+MB_SIZE_L+1
  - next accept possible in cycle N+MB_SIZE_L+2
  - each cycle mem_ready is low adds one cycle
- Arithmetic: sum = {1'b0,pred} + sign-extended resid, at 10 bits signed. Result = 0 if sum<0, 255 if sum>255, else sum[7:0]. Clipping happens at acceptance; only the clipped 8-bit MB is stored.
- Inputs are sampled only in the accept cycle; later changes are ignored.
- Asserting reset mid-WRITE immediately drops mem_we and returns to IDLE. Rows already written remain in memory; no done pulse is issued.
- mem_addr is not meaningful when mem_we=0.

Optional Feature:
- Macro: RECON_NEIGHBOUR_OUT_EN.
- When defined, add two outputs:
  - nb_bottom [8*MB_SIZE_W-1:0]: last row of the most recently completed MB.
  - nb_right [8*MB_SIZE_L-1:0]: last column of that MB.
  - Both update in the DONE cycle of a non-error MB, reset to all 128 (0x80), and hold otherwise.
- When not defined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package intrapred_pkg holds:
  - pixel_t (8-bit) and resid_t (9-bit signed)
  - the FSM state enum (IDLE, WRITE, DONE)
  - the PIXEL_MID=128 constant shared with the extractor
- Sub-module recon_clip: one combinational pixel adder/clipper (pred, resid -> pixel). It is instantiated MB_SIZE_L*MB_SIZE_W times via generate.

Test Plan:
- mbnumber=0, pred all 100, resid all +5, mem_ready=1 -> 16 writes at addr 0, 1280, ..., 19200, each data all 105. done at accept+17, err=0.
- mbnumber=81, same data -> mb_row=1, mb_col=1, base=16*1280+16=20496. Last write addr = 20496+15*1280 = 39696.
- Clipping: pred=250 with resid=+20, then pred=3 with resid=-9, then pred=128 with resid=-256 -> written 255, 0, 0.
- mbnumber=3600 (=MB_TOTAL) -> no mem_we at all. done=err=1 in the cycle after accept; in_ready returns high the following cycle.
- mem_ready low for 3 cycles during row 5 -> addr/data held stable for those cycles; done is delayed by exactly 3 cycles.
- reset pulsed during row 7 -> mem_we=0 asynchronously, in_ready=1 after release, no done. With RECON_NEIGHBOUR_OUT_EN, nb_bottom stays 0x80 repeated.
